// File: rtl/execute_pipe_pkg.sv
// execute_pipe_pkg: shared ALU opcode and writeback-select encodings for the RV32I execute stage
package execute_pipe_pkg;
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_SLTU  = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b1000;
    localparam logic [3:0] ALU_AND   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
endpackage

// File: rtl/execute_pipe_alu.sv
// alu_unit: combinational RV32I ALU
//   opa, opb     : operands (shift amount is opb[4:0])
//   alu_control  : operation select, unknown codes give 0
//   result       : operation result, modulo 2^XLEN
module alu_unit
    import execute_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  logic [3:0]      alu_control,
    output logic [XLEN-1:0] result
);
    logic [4:0] shamt;
    assign shamt = opb[4:0];
    always_comb begin
        result = '0;
        case (alu_control)
            ALU_ADD:   result = opa + opb;
            ALU_SUB:   result = opa - opb;
            ALU_SLL:   result = opa << shamt;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, opa < opb};
            ALU_XOR:   result = opa ^ opb;
            ALU_SRL:   result = opa >> shamt;
            ALU_SRA:   result = $signed(opa) >>> shamt;
            ALU_OR:    result = opa | opb;
            ALU_AND:   result = opa & opb;
            ALU_PASSB: result = opb;
            default:   result = '0;
        endcase
    end
endmodule

// File: rtl/execute_pipe.sv
// execute_pipe: RV32I execute stage and EX/MEM pipeline register
//   stall_in / flush_in  : hold / bubble the EX/MEM register (flush wins)
//   valid_in + controls  : ID/EX slot contents, side effects gated by valid_in
//   opa_in, opb_in       : ALU operands; opb_data_in is the store data
//   alu_fwd              : combinational ALU result for forwarding
//   valid..pc_plus4_out  : registered memory-stage controls and data
//   redirect(_target)    : registered taken branch/jump and its halfword-aligned target
module execute_pipe
    import execute_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    input  logic            flush_in,
    input  logic            valid_in,
    input  logic            load_in,
    input  logic            store_in,
    input  logic            next_sel_in,
    input  logic            branch_result_in,
    input  logic [3:0]      alu_control_in,
    input  logic [1:0]      mem_to_reg_in,
    input  logic [XLEN-1:0] opa_in,
    input  logic [XLEN-1:0] opb_in,
    input  logic [XLEN-1:0] opb_data_in,
    input  logic [XLEN-1:0] pc_plus4_in,
    output logic [XLEN-1:0] alu_fwd,
    output logic            valid,
    output logic            load,
    output logic            store,
    output logic [1:0]      mem_to_reg,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] pc_plus4_out,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_target
);
    logic            valid_q, valid_d;
    logic            load_q, load_d;
    logic            store_q, store_d;
    logic            redirect_q, redirect_d;
    logic [1:0]      mem_to_reg_q, mem_to_reg_d;
    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic [XLEN-1:0] store_data_q, store_data_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic [XLEN-1:0] redirect_target_q, redirect_target_d;

    alu_unit #(.XLEN(XLEN)) u_alu (
        .opa         (opa_in),
        .opb         (opb_in),
        .alu_control (alu_control_in),
        .result      (alu_fwd)
    );

    always_comb begin
        valid_d           = valid_q;
        load_d            = load_q;
        store_d           = store_q;
        redirect_d        = redirect_q;
        mem_to_reg_d      = mem_to_reg_q;
        alu_result_d      = alu_result_q;
        store_data_d      = store_data_q;
        pc_plus4_d        = pc_plus4_q;
        redirect_target_d = redirect_target_q;
        if (flush_in) begin
            valid_d           = 1'b0;
            load_d            = 1'b0;
            store_d           = 1'b0;
            redirect_d        = 1'b0;
            mem_to_reg_d      = WB_ALU;
            alu_result_d      = '0;
            store_data_d      = '0;
            pc_plus4_d        = '0;
            redirect_target_d = '0;
        end else if (!stall_in) begin
            // data always loads; only side-effect controls are gated by valid_in
            valid_d           = valid_in;
            load_d            = load_in & valid_in;
            store_d           = store_in & valid_in;
            redirect_d        = (next_sel_in | branch_result_in) & valid_in;
            mem_to_reg_d      = mem_to_reg_in;
            alu_result_d      = alu_fwd;
            store_data_d      = opb_data_in;
            pc_plus4_d        = pc_plus4_in;
            redirect_target_d = {alu_fwd[XLEN-1:1], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q           <= 1'b0;
            load_q            <= 1'b0;
            store_q           <= 1'b0;
            redirect_q        <= 1'b0;
            mem_to_reg_q      <= '0;
            alu_result_q      <= '0;
            store_data_q      <= '0;
            pc_plus4_q        <= '0;
            redirect_target_q <= '0;
        end else begin
            valid_q           <= valid_d;
            load_q            <= load_d;
            store_q           <= store_d;
            redirect_q        <= redirect_d;
            mem_to_reg_q      <= mem_to_reg_d;
            alu_result_q      <= alu_result_d;
            store_data_q      <= store_data_d;
            pc_plus4_q        <= pc_plus4_d;
            redirect_target_q <= redirect_target_d;
        end
    end

    assign valid           = valid_q;
    assign load            = load_q;
    assign store           = store_q;
    assign redirect        = redirect_q;
    assign mem_to_reg      = mem_to_reg_q;
    assign alu_result      = alu_result_q;
    assign store_data      = store_data_q;
    assign pc_plus4_out    = pc_plus4_q;
    assign redirect_target = redirect_target_q;
endmodule

// File: doc/execute_pipe.md
Name: execute_pipe

Overview:
- Execute stage plus EX/MEM pipeline register of the pipelined RV32I core.
- Consumes the registered outputs of the ID/EX register: load, store, next_sel, branch_result, alu_control, mem_to_reg, operand A/B mux values and rs2 store data.
- Computes the ALU result combinationally and registers it with the memory-stage controls after one cycle.
- Adds valid tracking, stall/flush control and a registered branch/jump redirect for the fetch stage.

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- stall_in  input  1  hold the EX/MEM register
- flush_in  input  1  insert a bubble into EX/MEM
- valid_in  input  1  ID/EX slot holds a real instruction
- load_in  input  1  instruction is a load
- store_in  input  1  instruction is a store
- next_sel_in  input  1  instruction is a jump (JAL/JALR)
- branch_result_in  input  1  branch condition taken
- alu_control_in  input  4  ALU op select
- mem_to_reg_in  input  2  writeback source select, passed through
- opa_in  input  XLEN  operand A
- opb_in  input  XLEN  operand B
- opb_data_in  input  XLEN  store data (rs2)
- pc_plus4_in  input  XLEN  link value, passed through
- alu_fwd  output  XLEN  combinational ALU result, for forwarding
- valid  output  1  EX/MEM slot valid
- load  output  1  registered load, gated by valid
- store  output  1  registered store, gated by valid
- mem_to_reg  output  2  registered writeback select
- alu_result  output  XLEN  registered ALU result, also the memory address
- store_data  output  XLEN  registered opb_data_in
- pc_plus4_out  output  XLEN  registered link value
- redirect  output  1  taken branch or jump, registered
- redirect_target  output  XLEN  registered ALU result with bit 0 forced to 0

Behaviour:
- ALU encoding (alu_control_in):
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT (signed), 0100 SLTU, 0101 XOR
  - 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASSB (LUI)
  - All other codes produce 0.
- Arithmetic: all arithmetic is modulo 2^XLEN with no overflow flag. Shift amount is opb[4:0]. SLT/SLTU produce 0 or 1 zero-extended.
- Timing: alu_fwd is purely combinational from the current inputs. All other outputs have 1-cycle latency.
- Reset: rst high clears every registered output to 0 immediately, independent of clk. Outputs stay 0 while rst is held. This applies mid-operation; there is no partial state.
- Each rising edge, in priority order:
  1. flush_in=1: valid, load, store and redirect go to 0. Data registers and mem_to_reg go to 0.
  2. Else stall_in=1: all registers hold their values.
  3. Else capture:
     - valid <= valid_in
     - load <= load_in & valid_in
     - store <= store_in & valid_in
     - redirect <= (next_sel_in | branch_result_in) & valid_in
     - mem_to_reg, alu_result, store_data, pc_plus4_out are loaded from the inputs
     - redirect_target <= {alu_fwd[XLEN-1:1], 1'b0}
- Simultaneous flush_in and stall_in: flush wins.
- Stall: redirect is held during a stall. It asserts for exactly one cycle per captured taken instruction unless held by a stall or cleared by a flush.
- Invalid slot: when valid_in=0, data registers still load but all side-effect outputs stay 0.

Decomposition:
- Shared package holds:
  - the ALU opcode constants (ALU_ADD … ALU_PASSB)
  - the mem_to_reg encoding constants (WB_ALU=0, WB_MEM=1, WB_PC4=2)
- One sub-module, alu_unit: purely combinational; inputs opa, opb, alu_control; output result. Reused by the single-cycle core.
- The register logic stays in execute_pipe.

Test Plan:
- Reset: assert rst mid-stream with valid/load/redirect at 1 → all outputs 0 at once, without a clock edge. Release → the first capture works normally.
- Arithmetic: ADD 0xFFFFFFFF+1 → alu_result 0 next cycle. SUB 0-1 → 0xFFFFFFFF. SRA 0x80000000 by opb=0x21 (amount 1) → 0xC0000000. SLT 0xFFFFFFFF vs 1 → 1, SLTU → 0. Code 1111 → 0.
- Stall hold: capture store with alu 0x100, data 0xDEAD, then stall_in=1 for 3 cycles while inputs change → outputs remain 0x100/0xDEAD/store=1. Release → new values appear.
- Flush priority: flush_in=1 and stall_in=1 together with valid load at the inputs → next cycle valid=0, load=0, alu_result=0.
- Redirect: JALR with opa=0x1001, opb=0, next_sel_in=1 → next cycle redirect=1, redirect_target=0x1000, pc_plus4_out passed through. Following unstalled non-branch → redirect=0.
- Invalid slot: valid_in=0 with load_in=1, store_in=1, branch_result_in=1 → load, store, redirect, valid all 0. alu_result updates.
